// File: rtl/adder_resp_capture_pkg.sv
// Shared DFT definitions for the adder response-capture block: FSM encodings and default sizing.
`ifndef ADDER_RESP_CAPTURE_PKG_SV
`define ADDER_RESP_CAPTURE_PKG_SV
package adder_resp_capture_pkg;

   localparam int DEF_N          = 16;
   localparam int DEF_SETTLE_CYC = 2;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SHIFT  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

endpackage
`endif

// File: rtl/resp_shift_reg.sv
// Shadow register for the captured adder response: parallel load of {cout,sum}, serial shift
// toward bit 0 with scan_in entering at the MSB.
module resp_shift_reg #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic         scan_in,
   input  logic [W-1:0] load_data,
   output logic [W-1:0] q
);

   logic [W-1:0] shadow_q;
   logic [W-1:0] shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (load) begin
         shadow_d = load_data;
      end else if (shift) begin
         shadow_d = {scan_in, shadow_q[W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign q = shadow_q;

endmodule

// File: rtl/adder_resp_capture.sv
// Adder response capture: pin pass-through in functional mode, and in test mode a settle/capture
// followed by an LSB-first serial unload of {cout,sum} under a valid/ready handshake.
module adder_resp_capture
   import adder_resp_capture_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sel,
   input  logic [N-1:0] sum,
   input  logic         cout,
   output logic [N-1:0] pin_sum,
   output logic         pin_cout,
   input  logic         cap_req,
   input  logic         scan_in,
   output logic         so,
   output logic         so_valid,
   input  logic         so_ready,
   output logic         busy,
   output logic         done
);

   localparam int               CNT_W       = $clog2(N + 2);
   localparam logic [CNT_W-1:0] BIT_LOAD    = CNT_W'(N + 1);
   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

   state_t           state_q, state_d;
   logic [3:0]       settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             load;
   logic             shift;
   logic [N:0]       shadow;

   // Dropping sel aborts from any state without a done pulse; rst still wins in the flops.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      load         = 1'b0;
      shift        = 1'b0;
      if (!sel) begin
         state_d      = ST_IDLE;
         settle_cnt_d = '0;
         bit_cnt_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cap_req) begin
                  state_d      = ST_SETTLE;
                  settle_cnt_d = '0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  load         = 1'b1;
                  state_d      = ST_SHIFT;
                  settle_cnt_d = '0;
                  bit_cnt_d    = BIT_LOAD;
               end else begin
                  settle_cnt_d = settle_cnt_q + 4'd1;
               end
            end
            ST_SHIFT: begin
               if (so_ready && (bit_cnt_q != '0)) begin
                  shift     = 1'b1;
                  bit_cnt_d = bit_cnt_q - 1'b1;
                  if (bit_cnt_q == CNT_W'(1)) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         bit_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
      end
   end

   resp_shift_reg #(
      .W (N + 1)
   ) u_shreg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .shift     (shift),
      .scan_in   (scan_in),
      .load_data ({cout, sum}),
      .q         (shadow)
   );

   // Pins depend only on sel so functional traffic is never disturbed by test-mode reset.
   assign pin_sum  = sel ? '0 : sum;
   assign pin_cout = sel ? 1'b0 : cout;

   assign so_valid = (state_q == ST_SHIFT);
   assign so       = so_valid & shadow[0];
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_adder_resp_capture.sv
// Scoreboard bench for adder_resp_capture: stimulus pushes expected serial bits, a monitor pops them.
module tb_adder_resp_capture;

   localparam int N = 16;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         rst, sel, cout, cap_req, scan_in, so_ready;
   logic [N-1:0] sum, pin_sum;
   logic         pin_cout, so, so_valid, busy, done;

   int checks = 0;
   int errors = 0;
   bit exp_bits[$];
   int done_pending = 0;
   bit stall_prev = 1'b0;
   bit stall_so = 1'b0;

   adder_resp_capture #(
      .N          (N),
      .SETTLE_CYC (S)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .sum      (sum),
      .cout     (cout),
      .pin_sum  (pin_sum),
      .pin_cout (pin_cout),
      .cap_req  (cap_req),
      .scan_in  (scan_in),
      .so       (so),
      .so_valid (so_valid),
      .so_ready (so_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference: the unload presents {cout,sum} one bit per handshake, LSB first.
   task automatic push_exp(input logic [N-1:0] s, input logic c);
      logic [N:0] word;
      word = {c, s};
      for (int i = 0; i <= N; i++) exp_bits.push_back(bit'((word >> i) & 1));
   endtask

   // Monitor: compares so on every handshake, stability while stalled, and done against the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (!so_valid) check("so_zero_outside_shift", so, 0);
         if (stall_prev && so_valid && sel) check("so_stable_stall", so, stall_so);
         if (so_valid && so_ready && sel) begin
            if (exp_bits.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL so_unexpected actual=%0b required=no_bit", so);
            end else begin
               check("so_bit", so, exp_bits.pop_front());
            end
         end
         if (done) begin
            check("done_expected", done_pending > 0, 1);
            check("done_bits_left", exp_bits.size(), 0);
            if (done_pending > 0) done_pending--;
         end
      end
      stall_prev = so_valid && !so_ready && sel && !rst;
      stall_so   = so;
   end

   // mode 0: always ready, 1: alternate stalls, 2: random stalls.
   task automatic run_unload(input int mode, input bit rearm);
      int edges, stalls;
      bit got, tog;
      edges = 1; stalls = 0; got = 0; tog = 0;
      for (int c = 0; c < 300 && !got; c++) begin
         case (mode)
            0:       so_ready = 1'b1;
            1:       begin so_ready = tog; tog = !tog; end
            default: so_ready = ($urandom_range(0, 2) != 0);
         endcase
         @(negedge clk);
         if (so_valid && !so_ready) stalls++;
         if (done) got = 1;
         else begin
            cyc();
            edges++;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done required=done");
         exp_bits.delete();
         done_pending = 0;
         so_ready = 1'b1;
         return;
      end
      check("done_latency", edges, S + N + 2 + stalls);
      if (rearm) cap_req = 1'b1;
      cyc();
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      so_ready = 1'b1;
   endtask

   task automatic capture(input logic [N-1:0] s, input logic c, input logic scan, input int mode);
      sum = s; cout = c; scan_in = scan; sel = 1'b1;
      push_exp(s, c);
      done_pending++;
      cap_req = 1'b1;
      cyc();
      cap_req = 1'b0;
      check("busy_settle", busy, 1);
      check("pin_sum_gated", pin_sum, 0);
      run_unload(mode, 0);
      check("shadow_after_unload", dut.shadow, {(N+1){scan}});
   endtask

   task automatic abort_at_bit5(input logic [N-1:0] s, input logic c, input bit use_rst);
      logic [N-1:0] s2;
      sum = s; cout = c; sel = 1'b1; so_ready = 1'b1; scan_in = 1'b0;
      push_exp(s, c);
      cap_req = 1'b1;
      cyc();
      cap_req = 1'b0;
      for (int k = 0; k < 100 && exp_bits.size() > N + 1 - 4; k++) cyc();
      check("abort_at_bit5_reached", so_valid, 1);
      if (use_rst) rst = 1'b1;
      else sel = 1'b0;
      cyc();
      rst = 1'b0;
      exp_bits.delete();
      check("abort_busy", busy, 0);
      check("abort_so_valid", so_valid, 0);
      check("abort_so", so, 0);
      check("abort_done", done, 0);
      if (use_rst) begin
         check("rst_shadow", dut.shadow, 0);
      end else begin
         check("abort_pin_sum", pin_sum, s);
         check("abort_pin_cout", pin_cout, c);
         s2 = N'($urandom);
         sum = s2;
         #1;
         check("abort_pin_sum_tracks", pin_sum, s2);
      end
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("no_done_after_abort", done, 0);
      end
      sel = 1'b1;
   endtask

   initial begin
      logic [N-1:0] r;
      rst = 1'b1; sel = 1'b0; sum = '0; cout = 1'b0;
      cap_req = 1'b0; scan_in = 1'b0; so_ready = 1'b1;
      cyc();
      cyc();
      check("rst_so", so, 0);
      check("rst_so_valid", so_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_shadow", dut.shadow, 0);
      rst = 1'b0;

      // Functional pass-through; cap_req must be ignored.
      sum = 16'h1234; cout = 1'b1; cap_req = 1'b1;
      cyc();
      check("pass_pin_sum", pin_sum, 16'h1234);
      check("pass_pin_cout", pin_cout, 1);
      check("pass_busy", busy, 0);
      cyc();
      check("pass_busy2", busy, 0);
      cap_req = 1'b0;
      sel = 1'b1;
      #1;
      check("gated_pin_sum", pin_sum, 0);
      check("gated_pin_cout", pin_cout, 0);
      cyc();

      capture(16'hA5C3, 1'b1, 1'b0, 0);
      capture(16'hA5C3, 1'b1, 1'b0, 1);
      capture(16'h0000, 1'b0, 1'b1, 0);
      abort_at_bit5(16'hA5C3, 1'b1, 1'b0);
      abort_at_bit5(N'($urandom), 1'b0, 1'b1);
      capture(16'h5A3C, 1'b0, 1'b0, 0);

      // Held cap_req restarts from IDLE on the cycle after DONE.
      sum = 16'h0F0F; cout = 1'b1; scan_in = 1'b0;
      push_exp(16'h0F0F, 1'b1);
      done_pending++;
      cap_req = 1'b1;
      cyc();
      cap_req = 1'b0;
      run_unload(0, 1);
      r = 16'hC001;
      sum = r; cout = 1'b0;
      push_exp(r, 1'b0);
      done_pending++;
      cyc();
      check("restart_busy", busy, 1);
      cap_req = 1'b0;
      run_unload(0, 0);

      for (int i = 0; i < 8; i++) begin
         r = N'($urandom);
         capture(r, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end
      check("final_pending", done_pending, 0);
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_resp_capture.md
ADDER_RESP_CAPTURE -- requirements
Module: adder_resp_capture

Interface
REQ-001 SHALL have parameter N, default 16: adder operand/sum width.
REQ-002 SHALL have parameter SETTLE_CYC, default 2, legal range 1..15: ripple-settle wait in cycles before capture.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sel  input  1  0 = functional mode, 1 = test mode.
REQ-006 SHALL have port sum  input  N  adder sum result.
REQ-007 SHALL have port cout  input  1  adder carry-out.
REQ-008 SHALL have port pin_sum  output  N  functional sum to chip pins.
REQ-009 SHALL have port pin_cout  output  1  functional carry to chip pins.
REQ-010 SHALL have port cap_req  input  1  test-mode capture request, sampled per cycle.
REQ-011 SHALL have port scan_in  input  1  serial chain input, enters shadow MSB.
REQ-012 SHALL have port so  output  1  serial response bit, LSB first.
REQ-013 SHALL have port so_valid  output  1  so holds a valid bit.
REQ-014 SHALL have port so_ready  input  1  tester accepts so this cycle.
REQ-015 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of unload.

Function
REQ-017 SHALL drive pin_sum=sum and pin_cout=cout combinationally when sel=0, and 0 on both when sel=1.
REQ-018 SHALL implement the FSM states IDLE, SETTLE, SHIFT and DONE.
REQ-019 SHALL move IDLE->SETTLE and clear the settle counter when cap_req=1 and sel=1 in IDLE; cap_req SHALL be ignored in all other states.
REQ-020 SHALL stay in SETTLE for exactly SETTLE_CYC cycles; on the edge ending the last SETTLE cycle it SHALL load the shadow register (N+1 bits) with {cout,sum} and enter SHIFT with the bit counter set to N+1.
REQ-021 SHALL, in SHIFT, assert so_valid=1 with so=shadow[0].
REQ-022 SHALL, on each cycle in SHIFT with so_valid and so_ready, shift the shadow right with scan_in into bit N and decrement the counter.
REQ-023 SHALL hold the shadow, the counter and so stable when so_ready=0.
REQ-024 SHALL move SHIFT->DONE on the handshake that takes the counter from 1 to 0.
REQ-025 SHALL assert done=1 for exactly one cycle in DONE and then return to IDLE.
REQ-026 SHALL hold so_valid=0 and so=0 outside SHIFT.
REQ-027 SHALL abort from any state to IDLE when sel falls to 0: clear the counters, drop so_valid, and raise no done pulse.
REQ-028 SHALL give rst priority over the sel abort.
REQ-029 SHALL require a fresh cap_req in IDLE after DONE (no auto-restart); a cap_req held high SHALL restart on the cycle after DONE.
REQ-030 SHALL size the counter as clog2(N+2) bits, with no wrap past 0.

Reset
REQ-031 SHALL, when rst=1 is sampled on an edge, set state=IDLE, shadow=0, both counters=0, so=0, so_valid=0, busy=0 and done=0.
REQ-032 SHALL let rst asserted mid-SETTLE or mid-SHIFT discard the capture, with no done pulse.
REQ-033 SHALL NOT gate pin_sum/pin_cout with rst; they remain purely sel-controlled.

Structure
REQ-034 SHALL place the FSM state encodings (2-bit) and the default N and SETTLE_CYC values in a shared DFT definitions package/header, with include-guarded usage.
REQ-035 SHALL instantiate one sub-module, resp_shift_reg, as the N+1-bit parallel-load/serial-shift register with load, shift and scan_in controls; FSM, counters and pin gating SHALL stay in the top module.

Verification
REQ-036 SHALL cover a functional pass-through case: sel=0, sum=16'h1234, cout=1 -> pin_sum=16'h1234, pin_cout=1, busy=0, and cap_req ignored.
REQ-037 SHALL cover a basic unload: sel=1, sum=16'hA5C3, cout=1, cap_req pulse, so_ready=1, scan_in=0 -> after 2 SETTLE cycles so_valid=1 for 17 cycles with so = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,1, then done high for 1 cycle, 20 cycles after the cap_req sample.
REQ-038 SHALL cover backpressure: same stimulus with so_ready low on alternate SHIFT cycles -> identical bit sequence, so stable while stalled, done delayed by the number of stall cycles.
REQ-039 SHALL cover sel abort: sel dropped to 0 at the 5th SHIFT bit -> next cycle state IDLE, so_valid=0, no done, and pin_sum tracks sum.
REQ-040 SHALL cover mid-shift reset: rst=1 for one cycle during SHIFT -> all outputs at reset values next cycle, and a subsequent cap_req restarts cleanly.
REQ-041 SHALL cover chain feed-through: scan_in=1 throughout with sum=0, cout=0 -> 17 zero bits out, after which the shadow reads all ones.
